sub_bytes_engine: RTL and testbench

Multi-lane sequential AES SubBytes/InvSubBytes engine for the AES datapath.
- Accepts a full state block through a valid/ready handshake.
- Substitutes LANES bytes per cycle in place, using either the forward S-box or the inverse S-box (FIPS-197).
- Returns the block through a second valid/ready handshake.
- Replaces per-byte combinational lookup instances in the round datapath, trading area for latency via LANES.

---
 rtl/sub_bytes_engine.sv | 199 +++++++++++++++++++
 tb/tb_sub_bytes_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_engine.sv
// rtl/sub_bytes_engine.sv - multi-lane sequential AES SubBytes/InvSubBytes engine
//
// Purpose:
//   Accepts one AES state block over a valid/ready handshake and substitutes
//   LANES bytes per cycle in place. The forward or inverse FIPS-197 S-box is
//   used, as selected by the mode captured with the block. The finished block
//   is returned over a second valid/ready handshake. BEATS = BLOCK_BYTES/LANES
//   substitution cycles are spent per block.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (aborts any block in flight)
//   inValid   in   upstream offers a block
//   inReady   out  engine is idle and can accept a block
//   inverse   in   0 = forward S-box, 1 = inverse S-box (sampled with dataIn)
//   dataIn    in   input block, byte k = dataIn[8k+7:8k]
//   outValid  out  dataOut holds a completed block
//   outReady  in   downstream accepts the completed block
//   dataOut   out  working buffer (substituted block once outValid is high)
//   busy      out  substitution in progress
module sub_bytes_engine #(
  parameter int BLOCK_BYTES = 16,
  parameter int LANES       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic                     inverse,
  input  logic [8*BLOCK_BYTES-1:0] dataIn,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [8*BLOCK_BYTES-1:0] dataOut,
  output logic                     busy
);

  localparam int BEATS = BLOCK_BYTES / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  // Only power-of-two lane counts that tile the block exactly are supported,
  // so the beat counter sweeps every byte exactly once and never wraps.
  generate
    if (!((LANES == 1) || (LANES == 2) || (LANES == 4) || (LANES == 8) || (LANES == 16))
        || ((BLOCK_BYTES % LANES) != 0)) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16 and divide BLOCK_BYTES");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [8*BLOCK_BYTES-1:0] buf_q, buf_d;
  logic                     mode_q, mode_d;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic with the AES polynomial x^8 + x^4 + x^3 + x + 1.
  // The S-box is computed rather than stored as a ROM: multiplicative inverse
  // followed by the affine map, and the reverse for the inverse S-box.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box definition needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // ---------------------------------------------------------------------------
  // Lane datapath: each lane picks its byte of the current beat and has its
  // own forward/inverse lookup pair; mode_q chooses which result is written.
  // ---------------------------------------------------------------------------
  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l]  = buf_q[(int'(cnt_q) * LANES + l) * 8 +: 8];
    assign lane_out[l] = mode_q ? sbox_inv(lane_in[l]) : sbox_fwd(lane_in[l]);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      buf_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      buf_q  <= buf_d;
      mode_q <= mode_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (inValid) state_d = S_SUB;
      S_SUB:   if (cnt_q == LAST_BEAT) state_d = S_DONE;
      S_DONE:  if (outReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: capture in IDLE, substitute one beat per SUB cycle.
  // DONE holds the buffer, and it is retained after the output handshake.
  always_comb begin
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    case (state_q)
      S_IDLE: begin
        if (inValid) begin
          buf_d  = dataIn;
          mode_d = inverse;
          cnt_d  = '0;
        end
      end
      S_SUB: begin
        for (int l = 0; l < LANES; l++) begin
          buf_d[(int'(cnt_q) * LANES + l) * 8 +: 8] = lane_out[l];
        end
        cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
      end
      S_DONE:  ;
      default: ;
    endcase
  end

  // Output decode
  always_comb begin
    inReady  = 1'b0;
    busy     = 1'b0;
    outValid = 1'b0;
    case (state_q)
      S_IDLE:  inReady  = 1'b1;
      S_SUB:   busy     = 1'b1;
      S_DONE:  outValid = 1'b1;
      default: ;
    endcase
  end

  assign dataOut = buf_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb/tb_sub_bytes_engine.sv - self-checking bench for sub_bytes_engine
module tb_sub_bytes_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, inverse, out_valid, out_ready, busy;
  logic [127:0] data_in, data_out;

  always #5 clk = ~clk;

  sub_bytes_engine #(.BLOCK_BYTES(16), .LANES(4)) dut (
    .clk(clk), .rst(rst),
    .inValid(in_valid), .inReady(in_ready), .inverse(inverse), .dataIn(data_in),
    .outValid(out_valid), .outReady(out_ready), .dataOut(data_out), .busy(busy)
  );

  // Lane-count sweep instances: 0 -> LANES=1, 1 -> LANES=2, 2 -> LANES=16
  logic         sw_valid, sw_inv, sw_out_ready;
  logic [127:0] sw_din;
  logic         sw_in_ready  [3];
  logic         sw_out_valid [3];
  logic         sw_busy      [3];
  logic [127:0] sw_dout      [3];

  for (genvar g = 0; g < 3; g++) begin : g_sw
    sub_bytes_engine #(.BLOCK_BYTES(16), .LANES(g == 0 ? 1 : (g == 1 ? 2 : 16))) u_sw (
      .clk(clk), .rst(rst),
      .inValid(sw_valid), .inReady(sw_in_ready[g]), .inverse(sw_inv), .dataIn(sw_din),
      .outValid(sw_out_valid[g]), .outReady(sw_out_ready), .dataOut(sw_dout[g]), .busy(sw_busy[g])
    );
  end

  localparam logic [127:0] T1_IN  = 128'h08_48_f8_e9_2a_8d_c6_9a_2b_e2_f4_a0_be_e3_3d_19;
  localparam logic [127:0] T1_OUT = 128'h30_52_41_1e_e5_5d_b4_b8_f1_98_bf_e0_ae_11_27_d4;

  int total = 0;
  int bad   = 0;

  // Reference tables built by walking the multiplicative group with generator 3
  logic [7:0] sbox_m  [256];
  logic [7:0] isbox_m [256];

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);   // p *= 3
      q = q ^ (q << 1);                             // q /= 3
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
      sbox_m[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_m[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_m[sbox_m[i]] = 8'(i);
  endtask

  function automatic logic [127:0] model_block(input logic [127:0] din, input logic inv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv ? isbox_m[din[8*k +: 8]] : sbox_m[din[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one block on the default instance, time it, check it, and drain it.
  task automatic run_block(input string tag, input logic [127:0] din, input logic inv,
                           input logic [127:0] exp);
    int lat;
    @(negedge clk);
    check({tag, ":inReady"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    data_in  = din;
    inverse  = inv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = rand128();
    inverse  = ~inv;
    check({tag, ":busy"}, 128'(busy), 128'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":latency"}, 128'(lat), 128'd4);
    check({tag, ":data"}, data_out, exp);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":drained"}, {126'd0, out_valid, in_ready}, 128'd1);
  endtask

  logic [127:0] blk_a, blk_b, exp_a, exp_b, blk;
  logic         rinv;
  int           lat;
  int           lat_sw [3];

  initial begin
    rst = 1'b1; in_valid = 1'b0; inverse = 1'b0; data_in = '0; out_ready = 1'b0;
    sw_valid = 1'b0; sw_inv = 1'b0; sw_din = '0; sw_out_ready = 1'b0;
    build_tables();
    #12;
    check("reset:inReady", 128'(in_ready), 128'd1);
    check("reset:outValid", 128'(out_valid), 128'd0);
    check("reset:busy", 128'(busy), 128'd0);
    check("reset:dataOut", data_out, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Known-answer vectors
    run_block("t1_fwd", T1_IN, 1'b0, T1_OUT);
    run_block("t2_inv", T1_OUT, 1'b1, T1_IN);
    run_block("zero_fwd", 128'd0, 1'b0, {16{8'h63}});
    run_block("x63_inv", {16{8'h63}}, 1'b1, 128'd0);
    run_block("anchor_fwd", {{14{8'h00}}, 8'hff, 8'h53}, 1'b0, {{14{8'h63}}, 8'h16, 8'hed});
    run_block("anchor_inv", {{14{8'h63}}, 8'h16, 8'hed}, 1'b1, {{14{8'h00}}, 8'hff, 8'h53});

    // Every byte value in both modes
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) blk[8*j +: 8] = 8'(16 * k + j);
      run_block($sformatf("table_fwd%0d", k), blk, 1'b0, model_block(blk, 1'b0));
      run_block($sformatf("table_inv%0d", k), blk, 1'b1, model_block(blk, 1'b1));
    end

    // Random blocks and modes
    for (int n = 0; n < 8; n++) begin
      blk  = rand128();
      rinv = 1'($urandom);
      run_block($sformatf("rand%0d", n), blk, rinv, model_block(blk, rinv));
    end

    // Backpressure: block B waits with inValid high while A is processed and held
    blk_a = rand128(); exp_a = model_block(blk_a, 1'b0);
    blk_b = rand128(); exp_b = model_block(blk_b, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; data_in = blk_a; inverse = 1'b0;
    @(posedge clk); #1;
    data_in = blk_b;
    lat = 0;
    while (!out_valid && lat < 40) begin
      check("bp:sub_inReady", 128'(in_ready), 128'd0);
      inverse = ~inverse;
      @(posedge clk); #1;
      lat++;
    end
    check("bp:latency", 128'(lat), 128'd4);
    inverse = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("bp:hold", {data_out, in_ready, out_valid}, {exp_a, 1'b0, 1'b1});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp:after_handshake", {data_out, in_ready, busy}, {exp_a, 1'b1, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp:b_accepted", 128'(busy), 128'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp:b_latency", 128'(lat), 128'd4);
    check("bp:b_data", data_out, exp_b);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset during the second SUB cycle
    @(negedge clk);
    in_valid = 1'b1; data_in = rand128(); inverse = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst_mid:outputs", {data_out, out_valid, busy, in_ready}, {128'd0, 1'b0, 1'b0, 1'b1});
    #1;
    rst = 1'b0;
    blk = rand128();
    run_block("after_rst", blk, 1'b1, model_block(blk, 1'b1));

    // Lane sweep with the known-answer vector
    @(negedge clk);
    for (int g = 0; g < 3; g++) check($sformatf("sweep%0d:inReady", g), 128'(sw_in_ready[g]), 128'd1);
    sw_valid = 1'b1; sw_din = T1_IN; sw_inv = 1'b0;
    @(posedge clk); #1;
    sw_valid = 1'b0; sw_din = rand128(); sw_inv = 1'b1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("sweep%0d:busy", g), 128'(sw_busy[g]), 128'd1);
      lat_sw[g] = -1;
    end
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) if (lat_sw[g] < 0 && sw_out_valid[g]) lat_sw[g] = cyc;
    end
    check("sweep_l1:latency", 128'(lat_sw[0]), 128'd16);
    check("sweep_l2:latency", 128'(lat_sw[1]), 128'd8);
    check("sweep_l16:latency", 128'(lat_sw[2]), 128'd1);
    for (int g = 0; g < 3; g++) check($sformatf("sweep%0d:data", g), sw_dout[g], T1_OUT);
    sw_out_ready = 1'b1;
    @(posedge clk); #1;
    sw_out_ready = 1'b0;
    for (int g = 0; g < 3; g++) check($sformatf("sweep%0d:idle", g), 128'(sw_in_ready[g]), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
